// File: rtl/gsm_filt_pkg.sv
// gsm_filt_pkg
// Shared definitions for the folded 51-tap GSM FIR: default frame geometry,
// the sequencer FSM state encoding and the fixed-point operand formats
// used by the datapath.
package gsm_filt_pkg;

    // Default frame geometry: 13 shared multipliers cover 51 folded taps
    // in 4 phases.
    localparam int unsigned NPHASE_DEF  = 4;
    localparam int unsigned PH_W_DEF    = 2;
    localparam int unsigned MAC_LAT_DEF = 0;

    // Datapath fixed-point formats, written as <int bits>s<frac bits>.
    localparam int unsigned FMT_2S16_INT  = 2;
    localparam int unsigned FMT_2S16_FRAC = 16;
    localparam int unsigned FMT_2S16_W    = FMT_2S16_INT + FMT_2S16_FRAC;
    localparam int unsigned FMT_1S17_INT  = 1;
    localparam int unsigned FMT_1S17_FRAC = 17;
    localparam int unsigned FMT_1S17_W    = FMT_1S17_INT + FMT_1S17_FRAC;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/gsm_strobe_delay.sv
// gsm_strobe_delay
// LAT-stage shift register for a bundle of strobes, cleared by an
// asynchronous active-low reset. With LAT=0 the input is passed straight
// through.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low clear of all stages
//   i_d     : strobe bundle in
//   o_q     : strobe bundle delayed by LAT cycles
module gsm_strobe_delay
    import gsm_filt_pkg::*;
#(
    parameter int unsigned LAT   = 0,
    parameter int unsigned WIDTH = 1
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (LAT == 0) begin : g_bypass
            // Clock and reset are not needed on the bypass path.
            logic w_unused;
            assign w_unused = &{1'b0, i_clk, i_rst_n};
            assign o_q      = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [LAT];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int unsigned i = 0; i < LAT; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_d;
                    for (int unsigned i = 1; i < LAT; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/gsm_mac_sequencer.sv
// gsm_mac_sequencer
// Control sequencer for the time-shared symmetric GSM FIR datapath. Each
// sam_clk_en pulse launches a frame of NPHASE phases; the sequencer drives
// the multiplier phase select, the accumulator clear/enable aligned to the
// MAC latency, and the output register load strobe. Coefficient bank swaps
// are applied only at frame starts; dropped sample strobes set overrun.
//   sys_clk       : system clock
//   reset         : asynchronous active-low reset
//   sam_clk_en    : one-cycle sample strobe, starts a frame
//   coef_swap_req : level request to toggle the coefficient bank
//   ovr_clr       : clears the overrun flag
//   phase         : multiplier operand / coefficient select
//   mac_valid     : phase is a valid frame phase
//   acc_clr       : accumulator loads instead of adding
//   acc_en        : accumulator updates
//   y_load        : output register captures the accumulator
//   coef_bank     : active coefficient bank
//   coef_swap_ack : one-cycle pulse when the bank toggles
//   busy          : frame in progress
//   overrun       : sticky, a sam_clk_en was dropped
module gsm_mac_sequencer
    import gsm_filt_pkg::*;
#(
    parameter int unsigned NPHASE  = NPHASE_DEF,
    parameter int unsigned PH_W    = PH_W_DEF,
    parameter int unsigned MAC_LAT = MAC_LAT_DEF
)(
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            sam_clk_en,
    input  logic            coef_swap_req,
    input  logic            ovr_clr,
    output logic [PH_W-1:0] phase,
    output logic            mac_valid,
    output logic            acc_clr,
    output logic            acc_en,
    output logic            y_load,
    output logic            coef_bank,
    output logic            coef_swap_ack,
    output logic            busy,
    output logic            overrun
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(NPHASE - 1);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [PH_W-1:0] r_phase;
    logic [PH_W-1:0] w_phase_nxt;
    logic            r_bank;
    logic            w_bank_nxt;
    logic            r_ack;
    logic            w_ack_nxt;
    logic            r_ovr;
    logic            w_ovr_nxt;
    logic            r_yload;

    logic            w_run;
    logic            w_last;
    logic            w_start;
    logic [2:0]      w_dly_in;
    logic [2:0]      w_dly_out;

    assign w_run   = (r_state == ST_RUN);
    assign w_last  = w_run && (r_phase == PH_LAST);
    // A new frame may start from IDLE or seamlessly from the last phase.
    assign w_start = sam_clk_en && (!w_run || w_last);

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_bank  <= 1'b0;
            r_ack   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_bank  <= w_bank_nxt;
            r_ack   <= w_ack_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bank_nxt  = r_bank;
        w_ack_nxt   = 1'b0;
        w_ovr_nxt   = r_ovr && !ovr_clr;

        if (w_start) begin
            w_state_nxt = ST_RUN;
            w_phase_nxt = '0;
            // Bank changes only here, so it is stable across a whole frame.
            if (coef_swap_req) begin
                w_bank_nxt = !r_bank;
                w_ack_nxt  = 1'b1;
            end
        end else if (w_run) begin
            if (w_last) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_phase_nxt = r_phase + PH_W'(1);
            end
        end

        // A strobe mid-frame is dropped; setting takes priority over ovr_clr.
        if (sam_clk_en && w_run && !w_last) begin
            w_ovr_nxt = 1'b1;
        end
    end

    // Strobes travel the MAC pipeline together: {enable, clear, last phase}.
    assign w_dly_in = {w_run, w_run && (r_phase == '0), w_last};

    gsm_strobe_delay #(
        .LAT   (MAC_LAT),
        .WIDTH (3)
    ) u_strobe_delay (
        .i_clk   (sys_clk),
        .i_rst_n (reset),
        .i_d     (w_dly_in),
        .o_q     (w_dly_out)
    );

    // Load the output one cycle after the last product reaches the
    // accumulator; this may share an edge with the next frame's acc_clr.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_yload <= 1'b0;
        end else begin
            r_yload <= w_dly_out[0];
        end
    end

    assign phase         = r_phase;
    assign mac_valid     = w_run;
    assign busy          = w_run;
    assign acc_en        = w_dly_out[2];
    assign acc_clr       = w_dly_out[1];
    assign y_load        = r_yload;
    assign coef_bank     = r_bank;
    assign coef_swap_ack = r_ack;
    assign overrun       = r_ovr;

endmodule

// File: tb/tb_gsm_mac_sequencer.sv
// tb_gsm_mac_sequencer
// Directed scoreboard bench. Two sequencers (MAC_LAT=0 and MAC_LAT=3) share
// the same stimulus. Stimulus pushes hand-computed output vectors tagged with
// the cycle they must appear in; a monitor on the falling edge compares them.
// Vector layout: {phase[1:0], mac_valid, acc_clr, acc_en, y_load,
//                 coef_bank, coef_swap_ack, busy, overrun}
module tb_gsm_mac_sequencer;

    logic       sys_clk;
    logic       rst_n;
    logic       sam_clk_en;
    logic       coef_swap_req;
    logic       ovr_clr;

    logic [1:0] phase0, phase3;
    logic       mv0, clr0, en0, yl0, bank0, ack0, busy0, ovr0;
    logic       mv3, clr3, en3, yl3, bank3, ack3, busy3, ovr3;
    logic [9:0] w_vec0, w_vec3;

    int         cyc;
    int         base;
    int         checks;
    int         failures;

    int         q_cyc[$];
    int         q_dut[$];
    logic [9:0] q_exp[$];
    string      q_tag[$];

    gsm_mac_sequencer #(
        .NPHASE  (4),
        .PH_W    (2),
        .MAC_LAT (0)
    ) u_dut0 (
        .sys_clk       (sys_clk),
        .reset         (rst_n),
        .sam_clk_en    (sam_clk_en),
        .coef_swap_req (coef_swap_req),
        .ovr_clr       (ovr_clr),
        .phase         (phase0),
        .mac_valid     (mv0),
        .acc_clr       (clr0),
        .acc_en        (en0),
        .y_load        (yl0),
        .coef_bank     (bank0),
        .coef_swap_ack (ack0),
        .busy          (busy0),
        .overrun       (ovr0)
    );

    gsm_mac_sequencer #(
        .NPHASE  (4),
        .PH_W    (2),
        .MAC_LAT (3)
    ) u_dut3 (
        .sys_clk       (sys_clk),
        .reset         (rst_n),
        .sam_clk_en    (sam_clk_en),
        .coef_swap_req (coef_swap_req),
        .ovr_clr       (ovr_clr),
        .phase         (phase3),
        .mac_valid     (mv3),
        .acc_clr       (clr3),
        .acc_en        (en3),
        .y_load        (yl3),
        .coef_bank     (bank3),
        .coef_swap_ack (ack3),
        .busy          (busy3),
        .overrun       (ovr3)
    );

    assign w_vec0 = {phase0, mv0, clr0, en0, yl0, bank0, ack0, busy0, ovr0};
    assign w_vec3 = {phase3, mv3, clr3, en3, yl3, bank3, ack3, busy3, ovr3};

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [9:0] V(input int ph, input bit mv, input bit clr,
                                     input bit en, input bit yl, input bit bk,
                                     input bit ak, input bit bs, input bit ov);
        logic [1:0] p;
        p = ph[1:0];
        return {p, mv, clr, en, yl, bk, ak, bs, ov};
    endfunction

    task automatic push_exp(input int dut, input int rel, input logic [9:0] v,
                            input string tag);
        q_cyc.push_back(base + rel);
        q_dut.push_back(dut);
        q_exp.push_back(v);
        q_tag.push_back(tag);
    endtask

    // Advance to #1 after the posedge that opens relative cycle r.
    task automatic goto(input int r);
        while (cyc < base + r) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        sam_clk_en    = 1'b0;
        coef_swap_req = 1'b0;
        ovr_clr       = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        base  = cyc;
    endtask

    task automatic pulse_sam(input int r);
        goto(r);
        sam_clk_en = 1'b1;
        goto(r + 1);
        sam_clk_en = 1'b0;
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge sys_clk) begin
        int i;
        logic [9:0] act;
        i = 0;
        while (i < q_cyc.size()) begin
            if (q_cyc[i] <= cyc) begin
                act = (q_dut[i] == 0) ? w_vec0 : w_vec3;
                checks++;
                if (q_cyc[i] < cyc) begin
                    failures++;
                    $display("FAIL %s dut%0d: expectation for cycle %0d not checked (now %0d), required %b",
                             q_tag[i], q_dut[i] == 0 ? 0 : 3, q_cyc[i], cyc, q_exp[i]);
                end else if (act !== q_exp[i]) begin
                    failures++;
                    $display("FAIL %s dut%0d cycle %0d: got %b required %b",
                             q_tag[i], q_dut[i] == 0 ? 0 : 3, cyc, act, q_exp[i]);
                end
                q_cyc.delete(i);
                q_dut.delete(i);
                q_exp.delete(i);
                q_tag.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ph;
        checks   = 0;
        failures = 0;
        base     = 0;

        // Reset and idle: nothing moves without a strobe.
        do_reset();
        for (int r = 0; r < 10; r++) begin
            push_exp(0, r, V(0,0,0,0,0,0,0,0,0), "idle");
        end
        push_exp(1, 5, V(0,0,0,0,0,0,0,0,0), "idle_lat3");
        goto(12);

        // Single frame on both latencies, strobe at 10.
        do_reset();
        push_exp(0, 10, V(0,0,0,0,0,0,0,0,0), "frame_pre");
        push_exp(0, 11, V(0,1,1,1,0,0,0,1,0), "frame");
        push_exp(1, 11, V(0,1,0,0,0,0,0,1,0), "lat3");
        push_exp(0, 12, V(1,1,0,1,0,0,0,1,0), "frame");
        push_exp(1, 12, V(1,1,0,0,0,0,0,1,0), "lat3");
        push_exp(0, 13, V(2,1,0,1,0,0,0,1,0), "frame");
        push_exp(1, 13, V(2,1,0,0,0,0,0,1,0), "lat3");
        push_exp(0, 14, V(3,1,0,1,0,0,0,1,0), "frame");
        push_exp(1, 14, V(3,1,1,1,0,0,0,1,0), "lat3");
        push_exp(0, 15, V(3,0,0,0,1,0,0,0,0), "frame_yload");
        push_exp(1, 15, V(3,0,0,1,0,0,0,0,0), "lat3");
        push_exp(0, 16, V(3,0,0,0,0,0,0,0,0), "frame_post");
        push_exp(1, 16, V(3,0,0,1,0,0,0,0,0), "lat3");
        push_exp(1, 17, V(3,0,0,1,0,0,0,0,0), "lat3");
        push_exp(1, 18, V(3,0,0,0,1,0,0,0,0), "lat3_yload");
        push_exp(1, 19, V(3,0,0,0,0,0,0,0,0), "lat3_post");
        pulse_sam(10);
        goto(21);

        // Back-to-back frames, strobes at 10, 14, 18.
        do_reset();
        for (int r = 11; r < 23; r++) begin
            ph = (r - 11) % 4;
            push_exp(0, r, V(ph, 1, ph == 0, 1, (r == 15) || (r == 19), 0, 0, 1, 0), "b2b");
        end
        push_exp(0, 23, V(3,0,0,0,1,0,0,0,0), "b2b_end");
        push_exp(0, 24, V(3,0,0,0,0,0,0,0,0), "b2b_idle");
        pulse_sam(10);
        pulse_sam(14);
        pulse_sam(18);
        goto(26);

        // Overrun: strobe at phase 1 dropped, later cleared; set beats clear.
        do_reset();
        push_exp(0, 11, V(0,1,1,1,0,0,0,1,0), "ovr_frame");
        push_exp(0, 12, V(1,1,0,1,0,0,0,1,0), "ovr_frame");
        push_exp(0, 13, V(2,1,0,1,0,0,0,1,1), "ovr_set");
        push_exp(0, 14, V(3,1,0,1,0,0,0,1,1), "ovr_frame");
        push_exp(0, 15, V(3,0,0,0,1,0,0,0,1), "ovr_yload");
        push_exp(0, 16, V(3,0,0,0,0,0,0,0,1), "ovr_sticky");
        push_exp(0, 20, V(3,0,0,0,0,0,0,0,1), "ovr_clr_cycle");
        push_exp(0, 21, V(3,0,0,0,0,0,0,0,0), "ovr_cleared");
        push_exp(0, 27, V(2,1,0,1,0,0,0,1,1), "ovr_set_wins");
        pulse_sam(10);
        pulse_sam(12);
        goto(20);
        ovr_clr = 1'b1;
        goto(21);
        ovr_clr = 1'b0;
        pulse_sam(24);
        goto(26);
        sam_clk_en = 1'b1;
        ovr_clr    = 1'b1;
        goto(27);
        sam_clk_en = 1'b0;
        ovr_clr    = 1'b0;
        goto(30);

        // Bank swap at frame boundary, then reset mid-frame.
        do_reset();
        push_exp(0, 12, V(1,1,0,1,0,0,0,1,0), "bank_hold");
        push_exp(0, 13, V(2,1,0,1,0,0,0,1,0), "bank_hold");
        push_exp(0, 14, V(3,1,0,1,0,0,0,1,0), "bank_hold");
        push_exp(0, 15, V(0,1,1,1,1,1,1,1,0), "bank_swap");
        push_exp(1, 15, V(0,1,0,1,0,1,1,1,0), "bank_swap_lat3");
        for (int r = 16; r < 20; r++) begin
            push_exp(0, r, V(0,0,0,0,0,0,0,0,0), "mid_reset");
            push_exp(1, r, V(0,0,0,0,0,0,0,0,0), "mid_reset_lat3");
        end
        push_exp(0, 21, V(0,0,0,0,0,0,0,0,0), "post_reset");
        push_exp(1, 21, V(0,0,0,0,0,0,0,0,0), "post_reset_lat3");
        push_exp(1, 22, V(0,0,0,0,0,0,0,0,0), "post_reset_lat3");
        pulse_sam(10);
        goto(12);
        coef_swap_req = 1'b1;
        goto(14);
        sam_clk_en = 1'b1;
        goto(15);
        sam_clk_en = 1'b0;
        goto(16);
        coef_swap_req = 1'b0;
        rst_n         = 1'b0;
        goto(20);
        rst_n = 1'b1;
        goto(24);

        checks++;
        if (q_cyc.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q_cyc.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
